// File: rtl/dither_frame_ctrl.sv
// Frame-synchronous sequencer around a combinational 2x2 ordered-dither stage:
// debounced switches, frame-boundary enable changes, temporal threshold rotation.
module dither_frame_ctrl #(
    parameter logic [15:0] DEB_CYCLES    = 16'd50000,
    parameter bit          VS_ACTIVE_LOW = 1'b1,
    parameter int          HW            = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [HW-1:0] hc,
    input  logic [HW-1:0] vc,
    input  logic [23:0]   pix_in,
    input  logic          hsync_in,
    input  logic          vsync_in,
    input  logic          blank_in,
    input  logic          sw_dither,
    input  logic          sw_temporal,
    output logic          dith_hc,
    output logic          dith_vc,
    output logic          dith_en,
    output logic [23:0]   dith_in,
    input  logic [23:0]   dith_out,
    output logic [11:0]   rgb_out,
    output logic          hsync_out,
    output logic          vsync_out,
    output logic          blank_out,
    output logic [1:0]    frame_phase
);

    localparam logic SYNC_IDLE = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_OFF,
        S_ARM_ON,
        S_ON,
        S_ARM_OFF
    } state_t;

    state_t      state;
    logic [1:0]  sw_meta;
    logic [1:0]  sw_sync;
    logic [1:0]  sw_last;
    logic [15:0] deb_cnt;
    logic        req_dither;
    logic        req_temporal;
    logic        temporal_en;
    logic        vs_act;
    logic        vs_act_prev;
    logic        fb;
    logic        hsync_d1;
    logic        vsync_d1;
    logic        blank_d1;
    logic        unused_bits;

    assign vs_act      = VS_ACTIVE_LOW ? ~vsync_in : vsync_in;
    assign fb          = vs_act & ~vs_act_prev;
    assign unused_bits = ^{hc[HW-1:1], vc[HW-1:1], dith_out[19:16], dith_out[11:8], dith_out[3:0]};

    // Both switches share one debounce counter: any change of either restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta      <= 2'b00;
            sw_sync      <= 2'b00;
            sw_last      <= 2'b00;
            deb_cnt      <= 16'd0;
            req_dither   <= 1'b0;
            req_temporal <= 1'b0;
            vs_act_prev  <= 1'b0;
        end else begin
            sw_meta     <= {sw_dither, sw_temporal};
            sw_sync     <= sw_meta;
            sw_last     <= sw_sync;
            vs_act_prev <= vs_act;
            if (sw_sync != sw_last) begin
                deb_cnt <= 16'd0;
            end else if (deb_cnt != DEB_CYCLES - 16'd1) begin
                deb_cnt <= deb_cnt + 16'd1;
            end else begin
                req_dither   <= sw_last[1];
                req_temporal <= sw_last[0];
            end
        end
    end

    // Requests only arm a change; the enable itself flips on a frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_OFF;
            dith_en     <= 1'b0;
            temporal_en <= 1'b0;
        end else begin
            case (state)
                S_OFF: begin
                    if (req_dither) state <= S_ARM_ON;
                end
                S_ARM_ON: begin
                    if (!req_dither) begin
                        state <= S_OFF;
                    end else if (fb) begin
                        state       <= S_ON;
                        dith_en     <= 1'b1;
                        temporal_en <= req_temporal;
                    end
                end
                S_ON: begin
                    if (!req_dither) state <= S_ARM_OFF;
                    if (fb) temporal_en <= req_temporal;
                end
                S_ARM_OFF: begin
                    if (req_dither) begin
                        state <= S_ON;
                    end else if (fb) begin
                        state   <= S_OFF;
                        dith_en <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_OFF;
                    dith_en <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !temporal_en) begin
            frame_phase <= 2'd0;
        end else if (fb) begin
            frame_phase <= frame_phase + 2'd1;
        end
    end

    // Two-stage pixel pipeline with matching sync/blank delay lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            dith_in   <= 24'h000000;
            dith_hc   <= 1'b0;
            dith_vc   <= 1'b0;
            rgb_out   <= 12'h000;
            hsync_d1  <= SYNC_IDLE;
            vsync_d1  <= SYNC_IDLE;
            blank_d1  <= 1'b1;
            hsync_out <= SYNC_IDLE;
            vsync_out <= SYNC_IDLE;
            blank_out <= 1'b1;
        end else begin
            dith_in   <= pix_in;
            dith_hc   <= hc[0] ^ frame_phase[0];
            dith_vc   <= vc[0] ^ frame_phase[1];
            rgb_out   <= blank_d1 ? 12'h000
                                  : {dith_out[23:20], dith_out[15:12], dith_out[7:4]};
            hsync_d1  <= hsync_in;
            vsync_d1  <= vsync_in;
            blank_d1  <= blank_in;
            hsync_out <= hsync_d1;
            vsync_out <= vsync_d1;
            blank_out <= blank_d1;
        end
    end

endmodule

// File: tb/tb_dither_frame_ctrl.sv
// Bench for dither_frame_ctrl: external dither stage, frame-level reference model
// compared every cycle, plus directed literal checks.
module tb_dither_frame_ctrl;

    localparam logic [15:0] DEB = 16'd16;
    localparam int          DEB_I = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hc = '0;
    logic [10:0] vc = '0;
    logic [23:0] pix_in = '0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        blank_in = 1'b1;
    logic        sw_dither = 1'b0;
    logic        sw_temporal = 1'b0;
    logic        dith_hc, dith_vc, dith_en;
    logic [23:0] dith_in;
    logic [23:0] dith_out;
    logic [11:0] rgb_out;
    logic        hsync_out, vsync_out, blank_out;
    logic [1:0]  frame_phase;

    int errors = 0;
    int checks = 0;

    dither_frame_ctrl #(
        .DEB_CYCLES(DEB),
        .VS_ACTIVE_LOW(1'b1),
        .HW(11)
    ) dut (
        .clk(clk), .rst(rst), .hc(hc), .vc(vc), .pix_in(pix_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
        .sw_dither(sw_dither), .sw_temporal(sw_temporal),
        .dith_hc(dith_hc), .dith_vc(dith_vc), .dith_en(dith_en),
        .dith_in(dith_in), .dith_out(dith_out), .rgb_out(rgb_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
        .frame_phase(frame_phase)
    );

    always #5 clk = ~clk;

    // External 2x2 ordered-dither stage: bump a channel nibble when its low
    // nibble exceeds the position threshold, saturating at 15.
    function automatic logic [7:0] dith_chan(input logic [7:0] c, input logic h,
                                             input logic v, input logic en);
        logic [3:0] thr;
        case ({v, h})
            2'b00:   thr = 4'd12;
            2'b01:   thr = 4'd4;
            2'b10:   thr = 4'd8;
            default: thr = 4'd0;
        endcase
        if (!en || c[3:0] <= thr || c[7:4] == 4'hF) return c;
        return {c[7:4] + 4'd1, c[3:0]};
    endfunction

    function automatic logic [23:0] dith_stage(input logic [23:0] p, input logic h,
                                               input logic v, input logic en);
        return {dith_chan(p[23:16], h, v, en), dith_chan(p[15:8], h, v, en),
                dith_chan(p[7:0], h, v, en)};
    endfunction

    always_comb dith_out = dith_stage(dith_in, dith_hc, dith_vc, dith_en);

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: enable follows the accepted request at each frame start,
    // phase counts frames while temporal mode is on, pixels take two cycles.
    logic        m_en, m_ten, m_req_d, m_req_t, m_vs_prev;
    logic [1:0]  m_phase, m_raw;
    int          m_cnt;
    logic [23:0] m_s1_pix;
    logic        m_s1_h, m_s1_v, m_s1_blank, m_s1_hs, m_s1_vs;
    logic [11:0] m_rgb;
    logic        m_hs, m_vs, m_blank;

    always @(posedge clk) begin
        logic        fbm;
        logic [23:0] d;
        logic [1:0]  nphase;
        if (rst) begin
            m_en = 0; m_ten = 0; m_req_d = 0; m_req_t = 0; m_vs_prev = 0;
            m_phase = 0; m_raw = 0; m_cnt = 0;
            m_s1_pix = 0; m_s1_h = 0; m_s1_v = 0; m_s1_blank = 1;
            m_s1_hs = 1; m_s1_vs = 1; m_rgb = 0; m_hs = 1; m_vs = 1; m_blank = 1;
        end else begin
            fbm = !vsync_in && !m_vs_prev;
            m_vs_prev = !vsync_in;
            d = dith_stage(m_s1_pix, m_s1_h, m_s1_v, m_en);
            m_rgb = m_s1_blank ? 12'h000 : {d[23:20], d[15:12], d[7:4]};
            m_hs = m_s1_hs; m_vs = m_s1_vs; m_blank = m_s1_blank;
            m_s1_pix = pix_in; m_s1_h = hc[0] ^ m_phase[0]; m_s1_v = vc[0] ^ m_phase[1];
            m_s1_blank = blank_in; m_s1_hs = hsync_in; m_s1_vs = vsync_in;
            nphase = !m_ten ? 2'd0 : (fbm ? m_phase + 2'd1 : m_phase);
            m_phase = nphase;
            if (fbm && m_req_d) m_ten = m_req_t;
            if (fbm) m_en = m_req_d;
            if ({sw_dither, sw_temporal} != m_raw) begin
                m_raw = {sw_dither, sw_temporal};
                m_cnt = 0;
            end else if (m_cnt < DEB_I) begin
                m_cnt++;
            end
            if (m_cnt >= DEB_I) {m_req_d, m_req_t} = m_raw;
        end
    end

    always begin
        @(posedge clk);
        #2;
        checkOutput("m_rgb", 32'(rgb_out), 32'(m_rgb));
        checkOutput("m_hsync", 32'(hsync_out), 32'(m_hs));
        checkOutput("m_vsync", 32'(vsync_out), 32'(m_vs));
        checkOutput("m_blank", 32'(blank_out), 32'(m_blank));
        checkOutput("m_en", 32'(dith_en), 32'(m_en));
        checkOutput("m_phase", 32'(frame_phase), 32'(m_phase));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [23:0] p, input logic h, input logic v,
                                 input logic b);
        pix_in = p; hc = {10'd0, h}; vc = {10'd0, v}; blank_in = b;
    endtask

    task automatic frame();
        vsync_in = 1'b0;
        step(2);
        vsync_in = 1'b1;
        step(4);
    endtask

    logic [11:0] temporal_rgb [5] = '{12'h777, 12'h888, 12'h777, 12'h888, 12'h777};

    initial begin
        step(3);
        checkOutput("rst_rgb", 32'(rgb_out), 32'h000);
        checkOutput("rst_blank", 32'(blank_out), 32'h1);
        checkOutput("rst_vsync", 32'(vsync_out), 32'h1);
        checkOutput("rst_hsync", 32'(hsync_out), 32'h1);
        checkOutput("rst_en", 32'(dith_en), 32'h0);
        checkOutput("rst_phase", 32'(frame_phase), 32'h0);

        rst = 1'b0;
        applyStimulus(24'h7C8D3F, 1'b0, 1'b0, 1'b0);
        hsync_in = 1'b0;
        step(1);
        checkOutput("hsync_d1", 32'(hsync_out), 32'h1);
        hsync_in = 1'b1;
        step(1);
        checkOutput("hsync_d2", 32'(hsync_out), 32'h0);
        checkOutput("pass_rgb", 32'(rgb_out), 32'h783);
        checkOutput("pass_blank", 32'(blank_out), 32'h0);

        sw_dither = 1'b1;
        step(DEB_I - 2);
        sw_dither = 1'b0;
        for (int f = 0; f < 3; f++) begin
            step(8);
            frame();
            checkOutput("glitch_en", 32'(dith_en), 32'h0);
        end

        sw_dither = 1'b1;
        step(DEB_I + 4);
        checkOutput("arm_en", 32'(dith_en), 32'h0);
        step(10);
        vsync_in = 1'b0;
        checkOutput("fb_cycle_en", 32'(dith_en), 32'h0);
        step(1);
        checkOutput("after_fb_en", 32'(dith_en), 32'h1);
        step(1);
        vsync_in = 1'b1;
        step(2);

        applyStimulus(24'h747474, 1'b1, 1'b1, 1'b0);
        step(2);
        checkOutput("dith_11", 32'(rgb_out), 32'h888);
        applyStimulus(24'h747474, 1'b0, 1'b1, 1'b0);
        step(2);
        checkOutput("dith_01", 32'(rgb_out), 32'h777);

        sw_temporal = 1'b1;
        applyStimulus(24'h767676, 1'b0, 1'b0, 1'b0);
        step(DEB_I + 10);
        frame();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) frame();
            checkOutput("temp_phase", 32'(frame_phase), 32'(k % 4));
            checkOutput("temp_rgb", 32'(rgb_out), 32'(temporal_rgb[k]));
        end

        applyStimulus(24'hF8F8F8, 1'b0, 1'b0, 1'b0);
        sw_dither = 1'b0;
        for (int i = 0; i < DEB_I + 10; i++) begin
            step(1);
            checkOutput("armoff_en", 32'(dith_en), 32'h1);
        end
        sw_dither = 1'b1;
        for (int i = 0; i < DEB_I + 10; i++) begin
            step(1);
            checkOutput("reon_en", 32'(dith_en), 32'h1);
        end
        checkOutput("sat_rgb", 32'(rgb_out), 32'hFFF);
        frame();
        checkOutput("still_on_en", 32'(dith_en), 32'h1);
        checkOutput("sat_rgb2", 32'(rgb_out), 32'hFFF);

        applyStimulus(24'hF8F8F8, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        checkOutput("mid_rst_phase", 32'(frame_phase), 32'h0);
        checkOutput("mid_rst_rgb", 32'(rgb_out), 32'h000);
        checkOutput("mid_rst_blank", 32'(blank_out), 32'h1);
        checkOutput("mid_rst_en", 32'(dith_en), 32'h0);
        step(1);
        checkOutput("post_rst_blank1", 32'(blank_out), 32'h1);
        step(1);
        checkOutput("post_rst_blank2", 32'(blank_out), 32'h0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
